// File: rtl/end_banner.sv
// End-of-game banner overlay. Slides a "WIN" or "LOSE" caption up from the
// bottom of the screen, holds it at its final row and optionally blinks it.
// The overlay colour is produced one clock after the pixel coordinate.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no banner; waiting for win or lose
//   SLIDE | banner moving up one SLIDE_STEP per frame_tick
//   HOLD  | banner parked at ORIGIN_Y; blink phase toggles every
//         | BLINK_FRAMES frame_ticks (never, if BLINK_FRAMES is 0)
module end_banner #(
  parameter int          ORIGIN_X     = 256,
  parameter int          ORIGIN_Y     = 200,
  parameter int          SCALE        = 4,
  parameter int          SLIDE_STEP   = 8,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] COLOR_WIN    = 24'hFFFFFF,
  parameter logic [23:0] COLOR_LOSE   = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  input  logic        frame_tick,
  input  logic        win,
  input  logic        lose,
  input  logic        clear,
  output logic [23:0] vga_color,
  output logic        overlay_on,
  output logic        banner_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLIDE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int SH = $clog2(SCALE);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  localparam logic [10:0] TOP_START = 11'd480;
  localparam logic [10:0] TOP_FINAL = 11'(ORIGIN_Y);

  logic [1:0]    r_state;
  logic          r_mode;     // 0 = WIN, 1 = LOSE
  logic [10:0]   r_top;
  logic [BW-1:0] r_cnt;
  logic          r_hid;      // blink phase: 1 = text hidden
  logic [23:0]   r_color;
  logic          r_overlay;
  logic          r_done;

  logic [1:0]    w_state_nx;
  logic          w_mode_nx;
  logic [10:0]   w_top_nx;
  logic [BW-1:0] w_cnt_nx;
  logic          w_hid_nx;
  logic [11:0]   w_dec;
  logic [10:0]   w_slid_top;

  // 5x7 font rows, top row in the most significant 5 bits, bit4 leftmost.
  function automatic logic [34:0] glyph_bits(input logic lose_mode, input logic [1:0] idx);
    logic [34:0] g;
    g = '0;
    case ({lose_mode, idx})
      3'b000: g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A}; // W
      3'b001: g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E}; // I
      3'b010: g = {5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11, 5'h11}; // N
      3'b100: g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F}; // L
      3'b101: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E}; // O
      3'b110: g = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E}; // S
      3'b111: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F}; // E
      default: g = '0;
    endcase
    return g;
  endfunction

  // Saturating upward step; the 12th bit catches a step larger than r_top.
  always_comb begin
    w_dec = {1'b0, r_top} - 12'(SLIDE_STEP);
    if (w_dec[11] || (w_dec[10:0] < TOP_FINAL)) w_slid_top = TOP_FINAL;
    else                                         w_slid_top = w_dec[10:0];
  end

  // Next-state logic for the FSM, mode, position and blink phase.
  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_top_nx   = r_top;
    w_cnt_nx   = r_cnt;
    w_hid_nx   = r_hid;
    if (clear) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (win || lose) begin
            w_state_nx = SLIDE;
            w_mode_nx  = ~win;
            w_top_nx   = TOP_START;
            w_cnt_nx   = '0;
            w_hid_nx   = 1'b0;
          end
        end
        SLIDE: begin
          if (r_top == TOP_FINAL) begin
            w_state_nx = HOLD;
            w_cnt_nx   = '0;
            w_hid_nx   = 1'b0;
          end else if (frame_tick) begin
            w_top_nx = w_slid_top;
          end
        end
        HOLD: begin
          if (frame_tick && (BLINK_FRAMES != 0)) begin
            if (r_cnt == BLINK_LAST) begin
              w_cnt_nx = '0;
              w_hid_nx = ~r_hid;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  logic        w_left;
  logic        w_above;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_gx;
  logic [10:0] w_gy;
  logic [10:0] w_glyph;
  logic [10:0] w_col;
  logic [10:0] w_nglyph;
  logic [34:0] w_gbits;
  logic [4:0]  w_rowbits;
  logic [4:0]  w_rowsh;
  logic        w_lit;

  // Map the screen coordinate onto a glyph pixel and look up the font bit.
  always_comb begin
    w_left    = {1'b0, x} < 11'(ORIGIN_X);
    w_above   = {1'b0, y} < r_top;
    w_dx      = {1'b0, x} - 11'(ORIGIN_X);
    w_dy      = {1'b0, y} - r_top;
    w_gx      = w_dx >> SH;
    w_gy      = w_dy >> SH;
    w_glyph   = w_gx / 11'd6;
    w_col     = w_gx % 11'd6;
    w_nglyph  = r_mode ? 11'd4 : 11'd3;
    w_gbits   = glyph_bits(r_mode, w_glyph[1:0]);
    w_rowbits = 5'(w_gbits >> (5 * (3'd6 - w_gy[2:0])));
    w_rowsh   = w_rowbits << w_col[2:0];
    w_lit     = active_pixels && (r_state != IDLE) && !r_hid && !w_left && !w_above
                && (w_glyph < w_nglyph) && (w_col < 11'd5) && (w_gy < 11'd7)
                && w_rowsh[4];
  end

  // Register state, outputs and the pixel colour; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_top     <= TOP_START;
      r_cnt     <= '0;
      r_hid     <= 1'b0;
      r_color   <= 24'h0;
      r_overlay <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_mode    <= w_mode_nx;
      r_top     <= w_top_nx;
      r_cnt     <= w_cnt_nx;
      r_hid     <= w_hid_nx;
      r_color   <= w_lit ? (r_mode ? COLOR_LOSE : COLOR_WIN) : 24'h0;
      r_overlay <= (w_state_nx != IDLE);
      r_done    <= (w_state_nx == HOLD);
    end
  end

  assign vga_color   = r_color;
  assign overlay_on  = r_overlay;
  assign banner_done = r_done;

endmodule

// File: tb/tb_end_banner.sv
// Self-checking bench for end_banner: a reference model of the banner
// (position, mode, blink phase, text rendering from the caption string)
// predicts every output, and scenario tasks compare the DUT against it.
module tb_end_banner;

  localparam int          OX    = 256;
  localparam int          OY    = 200;
  localparam int          SC    = 4;
  localparam int          STEP  = 8;
  localparam int          BLINK = 30;
  localparam logic [23:0] CWIN  = 24'hFFFFFF;
  localparam logic [23:0] CLOSE = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        active = 1'b0;
  logic        ft = 1'b0;
  logic        win = 1'b0;
  logic        lose = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] vga_color, vga_color_nb;
  logic        overlay_on, overlay_on_nb;
  logic        banner_done, banner_done_nb;

  end_banner dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active),
    .frame_tick(ft), .win(win), .lose(lose), .clear(clear),
    .vga_color(vga_color), .overlay_on(overlay_on), .banner_done(banner_done)
  );

  end_banner #(.BLINK_FRAMES(0)) dut_nb (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active),
    .frame_tick(ft), .win(win), .lose(lose), .clear(clear),
    .vga_color(vga_color_nb), .overlay_on(overlay_on_nb), .banner_done(banner_done_nb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit m_on = 0, m_hold = 0, m_lose = 0, m_hid = 0;
  int m_top = 480, m_ticks = 0;
  logic [23:0] exp_color = '0, exp_color_nb = '0;
  bit exp_ov = 0, exp_done = 0;

  function automatic logic [34:0] font(byte ch);
    case (ch)
      "W": return {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      "I": return {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      "N": return {5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11, 5'h11};
      "L": return {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      "O": return {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      "S": return {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      "E": return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: return '0;
    endcase
  endfunction

  function automatic logic [23:0] pix(int xx, int yy, bit act, bit hid);
    string msg;
    logic [34:0] f;
    int gx, gy, g, c;
    msg = m_lose ? "LOSE" : "WIN";
    if (!act || !m_on || hid) return '0;
    if (xx < OX || yy < m_top) return '0;
    gx = (xx - OX) / SC;
    gy = (yy - m_top) / SC;
    g  = gx / 6;
    c  = gx % 6;
    if (g >= msg.len() || c > 4 || gy > 6) return '0;
    f = font(msg[g]);
    return f[34 - 5 * gy - c] ? (m_lose ? CLOSE : CWIN) : '0;
  endfunction

  // Advance one clock: predict outputs from the pre-edge state, then update.
  task automatic step();
    logic [23:0] c, cn;
    c = '0;
    cn = '0;
    if (rst) begin
      c  = pix(int'(x), int'(y), active, m_hid);
      cn = pix(int'(x), int'(y), active, 1'b0);
    end
    if (!rst) begin
      m_on = 0; m_hold = 0; m_lose = 0; m_top = 480; m_ticks = 0; m_hid = 0;
    end else if (clear) begin
      m_on = 0; m_hold = 0;
    end else if (!m_on) begin
      if (win || lose) begin
        m_on = 1; m_lose = !win; m_top = 480; m_ticks = 0; m_hid = 0;
      end
    end else if (!m_hold) begin
      if (m_top == OY) begin
        m_hold = 1; m_ticks = 0; m_hid = 0;
      end else if (ft) begin
        m_top = (m_top - STEP < OY) ? OY : m_top - STEP;
      end
    end else if (ft && BLINK != 0) begin
      m_ticks++;
      if (m_ticks == BLINK) begin
        m_ticks = 0;
        m_hid = !m_hid;
      end
    end
    @(posedge clk);
    #1;
    exp_color = c;
    exp_color_nb = cn;
    exp_ov = m_on;
    exp_done = m_hold;
  endtask

  task automatic run_to_hold();
    ft = 1'b1;
    for (int i = 0; i < 80 && !m_hold; i++) step();
    ft = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; win = 1'b1; active = 1'b1; ft = 1'b1; x = 10'd256; y = 10'd200;
    step();
    step();
    n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL reset_overlay got %b exp %b", overlay_on, exp_ov); end
    n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL reset_done got %b exp %b", banner_done, exp_done); end
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL reset_color got %h exp %h", vga_color, exp_color); end
    n_cmp++; if (vga_color_nb !== exp_color_nb) begin n_err++; $display("FAIL reset_color_nb got %h exp %h", vga_color_nb, exp_color_nb); end
    rst = 1'b1; win = 1'b0; ft = 1'b0;
    step();
  endtask

  task automatic test_win_slide();
    win = 1'b1;
    step();
    win = 1'b0;
    n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL slide_overlay got %b exp %b", overlay_on, exp_ov); end
    for (int i = 1; i <= 35; i++) begin
      x = 10'(OX); y = 10'(m_top); active = 1'b1; ft = 1'b1;
      step();
      n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL slide_color tick %0d got %h exp %h", i, vga_color, exp_color); end
      n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL slide_done tick %0d got %b exp %b", i, banner_done, exp_done); end
    end
    ft = 1'b0;
    step();
    n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL hold_done got %b exp %b", banner_done, exp_done); end
  endtask

  task automatic test_pixels_hold();
    x = 10'd256; y = 10'd200; active = 1'b1;
    step();
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL px_256 got %h exp %h", vga_color, exp_color); end
    x = 10'd260;
    step();
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL px_260 got %h exp %h", vga_color, exp_color); end
    x = 10'd256; active = 1'b0;
    step();
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL px_inactive got %h exp %h", vga_color, exp_color); end
    for (int i = 0; i < 300; i++) begin
      x = 10'($urandom_range(240, 330)); y = 10'($urandom_range(190, 240)); active = 1'b1;
      step();
      n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL px_rand x=%0d y=%0d got %h exp %h", x, y, vga_color, exp_color); end
    end
  endtask

  task automatic test_priority();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL clear_overlay got %b exp %b", overlay_on, exp_ov); end
    win = 1'b1; lose = 1'b1;
    step();
    win = 1'b0;
    step();
    step();
    lose = 1'b0;
    run_to_hold();
    x = 10'd256; y = 10'd200; active = 1'b1;
    step();
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL prio_win_color got %h exp %h", vga_color, exp_color); end
    clear = 1'b1;
    step();
    clear = 1'b0; lose = 1'b1;
    step();
    lose = 1'b0;
    run_to_hold();
    x = 10'd256; y = 10'd200; active = 1'b1;
    step();
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL lose_color got %h exp %h", vga_color, exp_color); end
    n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL lose_done got %b exp %b", banner_done, exp_done); end
  endtask

  task automatic test_blink();
    int n[3] = '{30, 30, 100};
    x = 10'd256; y = 10'd200; active = 1'b1;
    foreach (n[k]) begin
      for (int i = 0; i < n[k]; i++) begin ft = 1'b1; step(); end
      ft = 1'b0;
      step();
      n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL blink_color phase %0d got %h exp %h", k, vga_color, exp_color); end
      n_cmp++; if (vga_color_nb !== exp_color_nb) begin n_err++; $display("FAIL noblink_color phase %0d got %h exp %h", k, vga_color_nb, exp_color_nb); end
    end
  endtask

  task automatic test_clear_slide();
    clear = 1'b1;
    step();
    clear = 1'b0; win = 1'b1;
    step();
    win = 1'b0; ft = 1'b1;
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0; ft = 1'b0;
    n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL clear_tick_overlay got %b exp %b", overlay_on, exp_ov); end
    n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL clear_tick_done got %b exp %b", banner_done, exp_done); end
    lose = 1'b1;
    step();
    lose = 1'b0; ft = 1'b1;
    repeat (6) step();
    x = 10'(OX); y = 10'(m_top); active = 1'b1;
    rst = 1'b0; win = 1'b1; lose = 1'b1;
    step();
    rst = 1'b1; win = 1'b0; lose = 1'b0; ft = 1'b0;
    n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL rst_slide_color got %h exp %h", vga_color, exp_color); end
    n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL rst_slide_overlay got %b exp %b", overlay_on, exp_ov); end
    n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL rst_slide_done got %b exp %b", banner_done, exp_done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 499) != 0);
      win    = ($urandom_range(0, 29) == 0);
      lose   = ($urandom_range(0, 29) == 0);
      clear  = ($urandom_range(0, 399) == 0);
      ft     = ($urandom_range(0, 2) == 0);
      active = ($urandom_range(0, 3) != 0);
      x = 10'($urandom_range(240, 360));
      y = 10'($urandom_range(OY - 8, 520));
      step();
      n_cmp++; if (vga_color !== exp_color) begin n_err++; $display("FAIL rand_color cyc %0d got %h exp %h", i, vga_color, exp_color); end
      n_cmp++; if (vga_color_nb !== exp_color_nb) begin n_err++; $display("FAIL rand_color_nb cyc %0d got %h exp %h", i, vga_color_nb, exp_color_nb); end
      n_cmp++; if (overlay_on !== exp_ov) begin n_err++; $display("FAIL rand_overlay cyc %0d got %b exp %b", i, overlay_on, exp_ov); end
      n_cmp++; if (banner_done !== exp_done) begin n_err++; $display("FAIL rand_done cyc %0d got %b exp %b", i, banner_done, exp_done); end
    end
    rst = 1'b1; win = 1'b0; lose = 1'b0; clear = 1'b0; ft = 1'b0;
  endtask

  initial begin
    test_reset();
    test_win_slide();
    test_pixels_hold();
    test_priority();
    test_blink();
    test_clear_slide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
